// File: rtl/reg_pkg.sv
// Shared definitions for the 8-bit register bank and its read/write sides.
// Widths, read-port state encoding and address sizing helper.
package reg_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } read_state_t;

  function automatic int addr_width(input int count);
    return $clog2(count);
  endfunction

endpackage

// File: rtl/reg_read_mux.sv
// Combinational register select; out-of-range indices read as zero
// and raise error, so any bank consumer can reuse it.
module reg_read_mux
  import reg_pkg::*;
#(
  parameter  int REGISTERS_COUNT = 2,
  localparam int AW = addr_width(REGISTERS_COUNT)
) (
  input  logic [DATA_WIDTH-1:0] memories [REGISTERS_COUNT-1:0],
  input  logic [AW-1:0]         index,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  error
);

  // No match means the index lies past the last register.
  always_comb begin
    data  = '0;
    error = 1'b1;
    for (int i = 0; i < REGISTERS_COUNT; i++) begin
      if (index == AW'(i)) begin
        data  = memories[i];
        error = 1'b0;
      end
    end
  end

endmodule

// File: rtl/register_read_port.sv
// Read side of the register bank: single reads and full dumps served
// over valid/ready, with every beat captured into output registers.
module register_read_port
  import reg_pkg::*;
#(
  parameter  int REGISTERS_COUNT = 2,
  localparam int AW = addr_width(REGISTERS_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] memories [REGISTERS_COUNT-1:0],
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_dump,
  input  logic [AW-1:0]         req_address,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [AW-1:0]         rsp_address,
  output logic                  rsp_last,
  output logic                  rsp_error
);

  localparam logic [AW-1:0] LAST_IDX = AW'(REGISTERS_COUNT - 1);
  localparam logic ONE_REG = (REGISTERS_COUNT == 1);

  read_state_t           state;
  logic [AW-1:0]         next_index;
  logic [AW-1:0]         sel_index;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_error;

  assign next_index = rsp_address + AW'(1);

  // One mux serves both the accept edge and dump advance edges.
  assign sel_index = (state == IDLE)
                   ? (req_dump ? '0 : req_address)
                   : next_index;

  reg_read_mux #(
    .REGISTERS_COUNT(REGISTERS_COUNT)
  ) u_mux (
    .memories(memories),
    .index   (sel_index),
    .data    (sel_data),
    .error   (sel_error)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_address <= '0;
      rsp_last    <= 1'b0;
      rsp_error   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            state       <= RESP;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_data    <= sel_data;
            rsp_address <= sel_index;
            rsp_last    <= req_dump ? ONE_REG : 1'b1;
            rsp_error   <= sel_error;
          end else begin
            req_ready <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            if (rsp_last) begin
              state     <= IDLE;
              rsp_valid <= 1'b0;
              req_ready <= 1'b1;
            end else begin
              rsp_data    <= sel_data;
              rsp_address <= next_index;
              rsp_last    <= (next_index == LAST_IDX);
              rsp_error   <= sel_error;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_register_read_port.sv
// Bench for register_read_port at 2, 3 and 4 registers, with a
// snapshot model of the bank checked against every response beat.
module tb_register_read_port;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem2 [1:0];
  logic       req_valid2, req_ready2, req_dump2;
  logic [0:0] req_address2;
  logic       rsp_valid2, rsp_ready2, rsp_last2, rsp_error2;
  logic [7:0] rsp_data2;
  logic [0:0] rsp_address2;

  logic [7:0] mem3 [2:0];
  logic       req_valid3, req_ready3, req_dump3;
  logic [1:0] req_address3;
  logic       rsp_valid3, rsp_ready3, rsp_last3, rsp_error3;
  logic [7:0] rsp_data3;
  logic [1:0] rsp_address3;

  logic [7:0] mem4 [3:0];
  logic       req_valid4, req_ready4, req_dump4;
  logic [1:0] req_address4;
  logic       rsp_valid4, rsp_ready4, rsp_last4, rsp_error4;
  logic [7:0] rsp_data4;
  logic [1:0] rsp_address4;

  register_read_port #(.REGISTERS_COUNT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .memories(mem2),
    .req_valid(req_valid2), .req_ready(req_ready2),
    .req_dump(req_dump2), .req_address(req_address2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
    .rsp_data(rsp_data2), .rsp_address(rsp_address2),
    .rsp_last(rsp_last2), .rsp_error(rsp_error2)
  );

  register_read_port #(.REGISTERS_COUNT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .memories(mem3),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_dump(req_dump3), .req_address(req_address3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_data(rsp_data3), .rsp_address(rsp_address3),
    .rsp_last(rsp_last3), .rsp_error(rsp_error3)
  );

  register_read_port #(.REGISTERS_COUNT(4)) u4 (
    .clk(clk), .rst_n(rst_n), .memories(mem4),
    .req_valid(req_valid4), .req_ready(req_ready4),
    .req_dump(req_dump4), .req_address(req_address4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
    .rsp_data(rsp_data4), .rsp_address(rsp_address4),
    .rsp_last(rsp_last4), .rsp_error(rsp_error4)
  );

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({rsp_valid4, rsp_data4, rsp_address4, rsp_last4,
         rsp_error4, req_ready4} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0",
               {rsp_valid4, rsp_data4, rsp_address4, rsp_last4,
                rsp_error4, req_ready4});
    end
    checks++;
    if ({req_ready2, rsp_valid2, req_ready3, rsp_valid3} !== 4'b0) begin
      errors++;
      $display("FAIL reset_small: got %b want 0000",
               {req_ready2, rsp_valid2, req_ready3, rsp_valid3});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready4 !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_clock: got %b want 0", req_ready4);
    end
    @(negedge clk);
    checks++;
    if ({req_ready2, req_ready3, req_ready4} !== 3'b111) begin
      errors++;
      $display("FAIL ready_after_release: got %b want 111",
               {req_ready2, req_ready3, req_ready4});
    end
  endtask

  task automatic test_single_two();
    mem2[1] = 8'hA5;
    mem2[0] = 8'h3C;
    req_valid2 = 1'b1;
    req_dump2 = 1'b0;
    req_address2 = 1'b1;
    rsp_ready2 = 1'b1;
    @(negedge clk);
    req_valid2 = 1'b0;
    checks++;
    if ({rsp_valid2, rsp_data2, rsp_address2, rsp_last2, rsp_error2,
         req_ready2} !== {1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_two: got %h want %h",
               {rsp_valid2, rsp_data2, rsp_address2, rsp_last2,
                rsp_error2, req_ready2},
               {1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0});
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid2, req_ready2} !== 2'b01) begin
      errors++;
      $display("FAIL single_two_idle: got %b want 01",
               {rsp_valid2, req_ready2});
    end
  endtask

  task automatic test_backpressure();
    logic [13:0] want;
    mem4[0] = 8'h3C;
    req_valid4 = 1'b1;
    req_dump4 = 1'b0;
    req_address4 = 2'd0;
    rsp_ready4 = 1'b0;
    @(negedge clk);
    req_valid4 = 1'b0;
    want = {1'b1, 8'h3C, 2'd0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid4, rsp_data4, rsp_address4, rsp_last4,
           rsp_error4, req_ready4} !== want) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: got %h want %h", i,
                 {rsp_valid4, rsp_data4, rsp_address4, rsp_last4,
                  rsp_error4, req_ready4}, want);
      end
      mem4[0] = 8'hFF;
      if (i == 4) rsp_ready4 = 1'b1;
      @(negedge clk);
    end
    checks++;
    if ({rsp_valid4, req_ready4} !== 2'b01) begin
      errors++;
      $display("FAIL backpressure_done: got %b want 01",
               {rsp_valid4, req_ready4});
    end
  endtask

  // Transaction on the 4-register port against a snapshot model:
  // each beat must equal the bank contents at its capture edge.
  task automatic run_txn4(input bit dump, input logic [1:0] addr,
                          input bit calm, input bit hold,
                          input bit nd, input logic [1:0] na);
    int n, fa, waited, stall;
    bit done;
    logic [7:0] exp_d;
    logic [13:0] want;
    n = dump ? 4 : 1;
    fa = dump ? 0 : int'(addr);
    req_valid4 = 1'b1;
    req_dump4 = dump;
    req_address4 = addr;
    waited = 0;
    while (!req_ready4 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (req_ready4 !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: got %b want 1", req_ready4);
      req_valid4 = 1'b0;
      return;
    end
    if (!calm && $urandom_range(0, 1) == 1)
      for (int i = 0; i < 4; i++) mem4[i] = 8'($urandom);
    exp_d = mem4[fa];
    rsp_ready4 = calm ? 1'b1 : 1'($urandom);
    @(negedge clk);
    if (hold) begin
      req_dump4 = nd;
      req_address4 = na;
    end else begin
      req_valid4 = 1'b0;
      req_dump4 = 1'($urandom);
      req_address4 = 2'($urandom);
    end
    for (int k = 0; k < n; k++) begin
      done = 1'b0;
      stall = 0;
      while (!done) begin
        want = {1'b1, exp_d, 2'(fa + k), (k == n - 1), 1'b0, 1'b0};
        checks++;
        if ({rsp_valid4, rsp_data4, rsp_address4, rsp_last4,
             rsp_error4, req_ready4} !== want) begin
          errors++;
          $display("FAIL beat[%0d]: got %h want %h", k,
                   {rsp_valid4, rsp_data4, rsp_address4, rsp_last4,
                    rsp_error4, req_ready4}, want);
        end
        if (!calm && $urandom_range(0, 1) == 1)
          for (int i = 0; i < 4; i++) mem4[i] = 8'($urandom);
        if (calm || stall >= 6 || $urandom_range(0, 2) != 0) begin
          rsp_ready4 = 1'b1;
          done = 1'b1;
          if (k < n - 1) exp_d = mem4[k + 1];
        end else begin
          rsp_ready4 = 1'b0;
          stall++;
        end
        @(negedge clk);
      end
    end
    checks++;
    if ({rsp_valid4, req_ready4} !== 2'b01) begin
      errors++;
      $display("FAIL txn_end: got %b want 01", {rsp_valid4, req_ready4});
    end
  endtask

  task automatic test_dump_directed();
    mem4[3] = 8'h44;
    mem4[2] = 8'h33;
    mem4[1] = 8'h22;
    mem4[0] = 8'h11;
    run_txn4(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++)
      run_txn4(1'($urandom), 2'($urandom), 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic test_back_to_back();
    run_txn4(1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 2'd0);
    run_txn4(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    run_txn4(1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 2'd3);
    run_txn4(1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic test_out_of_range();
    logic [1:0] a;
    logic [7:0] exp_d;
    logic [13:0] want;
    for (int i = 0; i < 8; i++) begin
      a = (i < 4) ? 2'(i) : 2'($urandom);
      for (int j = 0; j < 3; j++) mem3[j] = 8'($urandom);
      exp_d = 8'h00;
      for (int j = 0; j < 3; j++) if (int'(a) == j) exp_d = mem3[j];
      req_valid3 = 1'b1;
      req_dump3 = 1'b0;
      req_address3 = a;
      rsp_ready3 = 1'b1;
      checks++;
      if (req_ready3 !== 1'b1) begin
        errors++;
        $display("FAIL oor_ready[%0d]: got %b want 1", i, req_ready3);
      end
      @(negedge clk);
      req_valid3 = 1'b0;
      want = {1'b1, exp_d, a, 1'b1, (a == 2'd3), 1'b0};
      checks++;
      if ({rsp_valid3, rsp_data3, rsp_address3, rsp_last3,
           rsp_error3, req_ready3} !== want) begin
        errors++;
        $display("FAIL oor_beat[%0d]: got %h want %h", i,
                 {rsp_valid3, rsp_data3, rsp_address3, rsp_last3,
                  rsp_error3, req_ready3}, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_dump();
    for (int i = 0; i < 4; i++) mem4[i] = 8'($urandom);
    req_valid4 = 1'b1;
    req_dump4 = 1'b1;
    req_address4 = 2'd0;
    rsp_ready4 = 1'b1;
    @(negedge clk);
    req_valid4 = 1'b0;
    @(negedge clk);
    checks++;
    if ({rsp_valid4, rsp_address4, rsp_data4} !== {1'b1, 2'd1, mem4[1]}) begin
      errors++;
      $display("FAIL mid_dump_beat1: got %h want %h",
               {rsp_valid4, rsp_address4, rsp_data4},
               {1'b1, 2'd1, mem4[1]});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid4, rsp_data4, rsp_address4, rsp_last4,
         rsp_error4, req_ready4} !== 14'h0) begin
      errors++;
      $display("FAIL async_reset: got %h want 0",
               {rsp_valid4, rsp_data4, rsp_address4, rsp_last4,
                rsp_error4, req_ready4});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid4, req_ready4} !== 2'b01) begin
        errors++;
        $display("FAIL post_reset[%0d]: got %b want 01", i,
                 {rsp_valid4, req_ready4});
      end
    end
  endtask

  initial begin
    req_valid2 = 1'b0; req_dump2 = 1'b0; req_address2 = '0;
    rsp_ready2 = 1'b0;
    req_valid3 = 1'b0; req_dump3 = 1'b0; req_address3 = '0;
    rsp_ready3 = 1'b0;
    req_valid4 = 1'b0; req_dump4 = 1'b0; req_address4 = '0;
    rsp_ready4 = 1'b0;
    for (int i = 0; i < 2; i++) mem2[i] = 8'h00;
    for (int i = 0; i < 3; i++) mem3[i] = 8'h00;
    for (int i = 0; i < 4; i++) mem4[i] = 8'h00;
    test_reset();
    test_single_two();
    test_backpressure();
    test_dump_directed();
    test_out_of_range();
    test_back_to_back();
    test_random();
    test_reset_mid_dump();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
